// File: rtl/pipeline_pkg.sv
// Shared types and constants for the pipeline hazard controller:
// register address width, forwarding select encodings and the scoreboard slot.
package pipeline_pkg;

  localparam int REG_ADDR_W = 5;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  w_en;
    logic                  is_load;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic                  rs1_used;
    logic                  rs2_used;
  } slot_t;

  // x0 is hardwired to zero, so a write to it never counts as a producer.
  function automatic logic slot_writes(input slot_t s);
    return s.valid && s.w_en && (s.rd != '0);
  endfunction

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard controller for a 5-stage pipeline: shadow scoreboard of EX/MEM/WB,
// load-use stall, branch flush, memory freeze and operand forwarding selects.
module pipeline_ctrl
  import pipeline_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_rs1_used,
  input  logic        id_rs2_used,
  input  logic [4:0]  id_rd,
  input  logic        id_reg_w_en,
  input  logic        id_is_load,
  input  logic        ex_branch_taken,
  input  logic        mem_busy,
  output logic        stall_if,
  output logic        stall_id,
  output logic        flush_if_id,
  output logic        flush_id_ex,
  output logic        freeze,
  output logic [1:0]  fwd_rs1_sel,
  output logic [1:0]  fwd_rs2_sel,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  slot_t ex_q, ex_d;
  slot_t mem_q, mem_d;
  slot_t wb_q, wb_d;
  slot_t id_slot;
  logic  load_use;
  logic  stall_inc;
  logic  flush_inc;

  function automatic logic [1:0] fwd_sel(input slot_t mem_s, input slot_t wb_s,
                                         input logic [REG_ADDR_W-1:0] rs,
                                         input logic used);
    logic [1:0] sel;
    sel = FWD_RF;
    if (used && slot_writes(mem_s) && !mem_s.is_load && (mem_s.rd == rs)) begin
      sel = FWD_MEM;
    end else if (used && slot_writes(wb_s) && (wb_s.rd == rs)) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

  always_comb begin
    id_slot          = '0;
    id_slot.valid    = id_valid;
    id_slot.rd       = id_rd;
    id_slot.w_en     = id_reg_w_en;
    id_slot.is_load  = id_is_load;
    id_slot.rs1      = id_rs1;
    id_slot.rs2      = id_rs2;
    id_slot.rs1_used = id_rs1_used;
    id_slot.rs2_used = id_rs2_used;
  end

  always_comb begin
    load_use = id_valid && slot_writes(ex_q) && ex_q.is_load &&
               ((id_rs1_used && (id_rs1 == ex_q.rd)) ||
                (id_rs2_used && (id_rs2 == ex_q.rd)));
  end

  // Priority: memory freeze, then branch flush, then load-use stall.
  always_comb begin
    stall_if    = 1'b0;
    stall_id    = 1'b0;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    freeze      = 1'b0;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;
    ex_d        = ex_q;
    mem_d       = mem_q;
    wb_d        = wb_q;
    if (mem_busy) begin
      freeze   = 1'b1;
      stall_if = 1'b1;
      stall_id = 1'b1;
    end else if (ex_branch_taken) begin
      flush_if_id = 1'b1;
      flush_id_ex = 1'b1;
      flush_inc   = 1'b1;
      ex_d        = '0;
      mem_d       = ex_q;
      wb_d        = mem_q;
    end else if (load_use) begin
      stall_if    = 1'b1;
      stall_id    = 1'b1;
      flush_id_ex = 1'b1;
      stall_inc   = 1'b1;
      ex_d        = '0;
      mem_d       = ex_q;
      wb_d        = mem_q;
    end else begin
      ex_d  = id_slot;
      mem_d = ex_q;
      wb_d  = mem_q;
    end
  end

  always_comb begin
    fwd_rs1_sel = fwd_sel(mem_q, wb_q, ex_q.rs1, ex_q.rs1_used);
    fwd_rs2_sel = fwd_sel(mem_q, wb_q, ex_q.rs2, ex_q.rs2_used);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

  sat_counter #(.WIDTH(16)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  sat_counter #(.WIDTH(16)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush_inc),
    .count (flush_cnt)
  );

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 The block SHALL have these ports, clock and reset first; reset is asynchronous and active-high:
clk  in  1  sole clock, rising edge
rst  in  1  asynchronous, active-high reset
id_valid  in  1  ID stage holds a real instruction
id_rs1, id_rs2  in  5  ID source register addresses
id_rs1_used, id_rs2_used  in  1  source is actually read (opcode-decoded)
id_rd  in  5  ID destination register
id_reg_w_en  in  1  ID instruction writes rd (main-decoder reg_w_en)
id_is_load  in  1  ID instruction is a load
ex_branch_taken  in  1  EX resolved a taken branch or jump this cycle
mem_busy  in  1  data memory not ready; freeze whole pipeline
stall_if  out  1  hold PC and IF/ID register
stall_id  out  1  hold ID stage; insert bubble into ID/EX
flush_if_id  out  1  IF/ID register loads a bubble
flush_id_ex  out  1  ID/EX register loads a bubble
freeze  out  1  all pipeline registers hold
fwd_rs1_sel, fwd_rs2_sel  out  2  EX operand source: 00 regfile, 01 MEM ALU result, 10 WB result
stall_cnt  out  16  load-use stall cycles, saturating
flush_cnt  out  16  branch flush events, saturating

Function
REQ-002 The block SHALL keep a shadow scoreboard of 3 slots (EX, MEM, WB), each {valid, rd, w_en, is_load, rs1, rs2, rs1_used, rs2_used}.
REQ-003 A slot's write SHALL be effective only when valid=1, w_en=1 and rd!=0; x0 never creates a hazard or forward.
REQ-004 load_use SHALL be 1 when id_valid, EX slot is an effective load write, and (id_rs1_used and id_rs1==ex.rd) or (id_rs2_used and id_rs2==ex.rd).
REQ-005 Priority per cycle SHALL be: mem_busy > ex_branch_taken > load_use > normal advance.
REQ-006 mem_busy=1: freeze=1, stall_if=stall_id=1, flush_*=0, scoreboard holds, counters hold.
REQ-007 Branch (no freeze): flush_if_id=flush_id_ex=1, stall_*=0; EX slot loads a bubble; MEM<=EX, WB<=MEM; flush_cnt +1; load_use ignored.
REQ-008 Load-use (no freeze, no branch): stall_if=stall_id=1, flush_id_ex=1; EX slot loads a bubble; MEM<=EX, WB<=MEM; stall_cnt +1; exactly one stall cycle per load-use pair.
REQ-009 Normal: WB<=MEM, MEM<=EX, EX<=ID fields with valid=id_valid; all control outputs 0.
REQ-010 fwd_rsN_sel SHALL be combinational from current slots: 01 if MEM effective, not load, and mem.rd==ex.rsN with ex.rsN_used; else 10 if WB effective and wb.rd==ex.rsN with ex.rsN_used; else 00. MEM beats WB.
REQ-011 MEM-slot load matching an EX source SHALL never occur (prevented by REQ-008); verification asserts it.
REQ-012 ID-read versus same-cycle WB-write overlap is resolved by the register file's write-first read; this block generates no select for it.
REQ-013 Control outputs and fwd selects SHALL be combinational with zero-cycle latency; scoreboard and counters update on rising clk.
REQ-014 Counters SHALL saturate at 16'hFFFF and never wrap.

Reset
REQ-015 rst=1 SHALL clear all slot valid bits, all slot fields, stall_cnt and flush_cnt to 0, immediately and independent of clk.
REQ-016 During and after reset, with id_valid=0, all control outputs SHALL be 0 and fwd selects 00.
REQ-017 Reset mid-stall or mid-flush SHALL abandon the event with no counter increment.

Structure
REQ-018 A shared package pipeline_pkg SHALL hold REG_ADDR_W=5, the fwd_sel encodings (FWD_RF, FWD_MEM, FWD_WB) and the scoreboard slot struct.
REQ-019 One sub-module sat_counter (16-bit, inc enable, async active-high reset) SHALL be instantiated twice.

Verification
REQ-020 Load x5 in EX, ID add uses rs1=x5 -> one cycle stall_if=stall_id=flush_id_ex=1, stall_cnt=1; two cycles later fwd_rs1_sel=10.
REQ-021 ALU writes x7 in MEM, EX reads rs2=x7; WB also writes x7 -> fwd_rs2_sel=01 (MEM priority).
REQ-022 ex_branch_taken=1 with simultaneous load-use -> flush_if_id=flush_id_ex=1, stall_*=0, flush_cnt+1, stall_cnt unchanged.
REQ-023 mem_busy=1 for 3 cycles during a load-use hazard -> freeze=1, scoreboard and counters hold; stall issued once on release.
REQ-024 Writes to x0 in EX/MEM/WB matching sources -> no stall, fwd selects 00.
REQ-025 Force stall_cnt to 16'hFFFE, two further load-use stalls -> 16'hFFFF held; rst mid-stall -> counters 0 without clk.
